ex_mem: RTL
===========

# ex_mem

Pipeline register slice between the EX stage and the MEM stage of the NPC core. It captures EX results and the control fields that EX passes through, and presents them to MEM under a valid/ready handshake. A two-entry buffer (main plus skid) keeps full throughput while the ready signal toward EX stays registered. A synchronous flush turns the slice into a bubble when a redirect or trap occurs.

## Interface
- No module parameters. Field widths come from the sysconfig.v macros: `XLEN, `INST_LEN, `REG_ADDRWIDTH, `CSR_ADDRWIDTH, `MEMOP_LEN, `EXCOP_LEN, `CSROP_LEN, `TRAP_LEN.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_valid  in  1  EX presents a valid payload.
- o_ready  out  1  slice can accept this cycle; registered.
- i_flush  in  1  synchronous kill of all held and incoming entries.
- i_pc / o_pc  in/out  `XLEN  instruction PC.
- i_inst_data / o_inst_data  in/out  `INST_LEN  instruction word.
- i_alu_result / o_alu_result  in/out  `XLEN  ALU result or memory address.
- i_rs2_data / o_rs2_data  in/out  `XLEN  store data.
- i_csr_wdata / o_csr_wdata  in/out  `XLEN  CSR write value.
- i_rd_idx / o_rd_idx  in/out  `REG_ADDRWIDTH  destination register.
- i_csr_addr / o_csr_addr  in/out  `CSR_ADDRWIDTH  CSR address.
- i_memop / o_memop  in/out  `MEMOP_LEN  memory op.
- i_exc_op / o_exc_op  in/out  `EXCOP_LEN  exception op.
- i_csr_op / o_csr_op  in/out  `CSROP_LEN  CSR op.
- i_trap_bus / o_trap_bus  in/out  `TRAP_LEN  trap info.
- o_valid  out  1  main entry valid toward MEM.
- i_ready  in  1  MEM accepts this cycle.

## Operation
- Storage:
  - Main entry: main_valid plus the full payload. It drives all o_* outputs directly.
  - Skid entry: skid_valid plus the full payload.
- Handshake events:
  - acc = i_valid & o_ready
  - fire = o_valid & i_ready
  - o_valid = main_valid
  - o_ready = ~skid_valid
- States, encoded as {main_valid, skid_valid}:
  - EMPTY = 00, ONE = 10, FULL = 11. State 01 is unreachable.
- EMPTY:
  - acc: load main from input, go to ONE.
  - otherwise: stay.
- ONE:
  - fire & acc: main reloads from input, stay ONE.
  - fire & !acc: go to EMPTY.
  - !fire & acc: skid loads from input, go to FULL.
  - !fire & !acc: hold.
- FULL (acc is impossible because o_ready = 0):
  - fire: main loads from skid, skid_valid clears, go to ONE.
  - !fire: hold.
- Ordering: entries leave in acceptance order. Skid always holds the entry younger than main.
- Flush (i_flush = 1 at an edge):
  - main_valid and skid_valid clear; next state is EMPTY.
  - An entry accepted in the same cycle is discarded.
  - Main o_memop, o_exc_op, o_csr_op, o_trap_bus and o_rd_idx are forced to 0 (bubble).
  - Data fields keep their old values.
  - Flush has priority over fire and acc.
  - A fire in the flush cycle still counts as consumed by MEM.
- Held payloads never change while their valid bit is set and not advancing, even if inputs toggle.

## Timing
- Reset (rst low, asynchronous):
  - All outputs reset: o_valid = 0, every o_* payload field = 0.
  - Both entries go invalid and o_ready = 1 from the first edge after release.
  - Reset asserted mid-transfer drops all entries immediately, without waiting for a clock edge.
- Latency: an input accepted at edge N appears on o_* with o_valid = 1 after edge N, when the slice was EMPTY or firing.
- Throughput: 1 entry per cycle with i_ready held at 1. o_ready stays 1 and the skid is never used.
- Backpressure:
  - One cycle of i_ready = 0 while ONE with i_valid = 1 fills the skid.
  - o_ready drops after that edge.
  - It rises again the edge after the first fire.
- o_ready depends only on flops. No combinational path from i_ready or i_valid to o_ready.
- Nothing in the slice depends combinationally on i_ready.

## Test plan
- Reset then stream: release rst, drive pc = 0x80000000, 0x80000004 and 0x80000008 on consecutive cycles with i_ready = 1 -> o_pc shows each value one cycle later, o_valid = 1 for 3 cycles, o_ready stays 1.
- Backpressure fill: with ONE holding pc = 0x100, set i_ready = 0 and drive pc = 0x104 valid -> skid fills, o_ready = 0 next cycle, o_pc holds 0x100. With 0x108 still driven, raise i_ready -> outputs in order 0x100, 0x104, 0x108; no loss or duplicate.
- Hold stability: in FULL with i_ready = 0 for 5 cycles while inputs randomise -> o_* unchanged, o_valid = 1, o_ready = 0.
- Flush in FULL: main pc = 0x200 with memop = 3, skid pc = 0x204, assert i_flush for one cycle -> next cycle o_valid = 0, o_memop = 0, o_rd_idx = 0, o_ready = 1. The following accept of pc = 0x300 appears next, not 0x204.
- Flush with simultaneous accept: EMPTY, i_valid = 1 with pc = 0x400 and i_flush = 1 -> o_valid stays 0; 0x400 never emitted.
- Async reset mid-operation: FULL, pull rst low between edges -> o_valid = 0 and all o_* = 0 immediately; o_ready = 1 after release.

Source files
------------

// File: rtl/ex_mem.sv
// EX->MEM pipeline slice: main + skid entry so o_ready can come straight from a flop.
// A flush kills both entries and zeroes the control fields of the main entry.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 5
`endif
`ifndef CSR_ADDRWIDTH
`define CSR_ADDRWIDTH 12
`endif
`ifndef MEMOP_LEN
`define MEMOP_LEN 4
`endif
`ifndef EXCOP_LEN
`define EXCOP_LEN 3
`endif
`ifndef CSROP_LEN
`define CSROP_LEN 3
`endif
`ifndef TRAP_LEN
`define TRAP_LEN 8
`endif

module ex_mem (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic                      i_flush,
    input  logic [`XLEN-1:0]          i_pc,
    input  logic [`INST_LEN-1:0]      i_inst_data,
    input  logic [`XLEN-1:0]          i_alu_result,
    input  logic [`XLEN-1:0]          i_rs2_data,
    input  logic [`XLEN-1:0]          i_csr_wdata,
    input  logic [`REG_ADDRWIDTH-1:0] i_rd_idx,
    input  logic [`CSR_ADDRWIDTH-1:0] i_csr_addr,
    input  logic [`MEMOP_LEN-1:0]     i_memop,
    input  logic [`EXCOP_LEN-1:0]     i_exc_op,
    input  logic [`CSROP_LEN-1:0]     i_csr_op,
    input  logic [`TRAP_LEN-1:0]      i_trap_bus,
    output logic [`XLEN-1:0]          o_pc,
    output logic [`INST_LEN-1:0]      o_inst_data,
    output logic [`XLEN-1:0]          o_alu_result,
    output logic [`XLEN-1:0]          o_rs2_data,
    output logic [`XLEN-1:0]          o_csr_wdata,
    output logic [`REG_ADDRWIDTH-1:0] o_rd_idx,
    output logic [`CSR_ADDRWIDTH-1:0] o_csr_addr,
    output logic [`MEMOP_LEN-1:0]     o_memop,
    output logic [`EXCOP_LEN-1:0]     o_exc_op,
    output logic [`CSROP_LEN-1:0]     o_csr_op,
    output logic [`TRAP_LEN-1:0]      o_trap_bus,
    output logic                      o_valid,
    input  logic                      i_ready
);

    // State bits are {main_valid, skid_valid}; 01 cannot occur.
    typedef enum logic [1:0] {
        S_EMPTY = 2'b00,
        S_ONE   = 2'b10,
        S_FULL  = 2'b11
    } state_t;

    typedef struct packed {
        logic [`XLEN-1:0]          pc;
        logic [`INST_LEN-1:0]      inst_data;
        logic [`XLEN-1:0]          alu_result;
        logic [`XLEN-1:0]          rs2_data;
        logic [`XLEN-1:0]          csr_wdata;
        logic [`REG_ADDRWIDTH-1:0] rd_idx;
        logic [`CSR_ADDRWIDTH-1:0] csr_addr;
        logic [`MEMOP_LEN-1:0]     memop;
        logic [`EXCOP_LEN-1:0]     exc_op;
        logic [`CSROP_LEN-1:0]     csr_op;
        logic [`TRAP_LEN-1:0]      trap_bus;
    } payload_t;

    state_t   r_state;
    payload_t r_main;
    payload_t r_skid;
    payload_t w_in;
    logic     w_acc;
    logic     w_fire;

    assign w_in = {i_pc, i_inst_data, i_alu_result, i_rs2_data, i_csr_wdata,
                   i_rd_idx, i_csr_addr, i_memop, i_exc_op, i_csr_op, i_trap_bus};

    // Handshake: a beat moves on an edge where valid and ready are both high.
    // o_ready is the inverted skid flop, so it never sees i_valid/i_ready.
    assign o_valid = r_state[1];
    assign o_ready = ~r_state[0];
    assign w_acc   = i_valid & o_ready;
    assign w_fire  = o_valid & i_ready;

    assign o_pc         = r_main.pc;
    assign o_inst_data  = r_main.inst_data;
    assign o_alu_result = r_main.alu_result;
    assign o_rs2_data   = r_main.rs2_data;
    assign o_csr_wdata  = r_main.csr_wdata;
    assign o_rd_idx     = r_main.rd_idx;
    assign o_csr_addr   = r_main.csr_addr;
    assign o_memop      = r_main.memop;
    assign o_exc_op     = r_main.exc_op;
    assign o_csr_op     = r_main.csr_op;
    assign o_trap_bus   = r_main.trap_bus;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
        end else if (i_flush) begin
            // Bubble: side-effecting control fields cleared, data left as is.
            r_state         <= S_EMPTY;
            r_main.rd_idx   <= '0;
            r_main.memop    <= '0;
            r_main.exc_op   <= '0;
            r_main.csr_op   <= '0;
            r_main.trap_bus <= '0;
        end else begin
            case (r_state)
                S_EMPTY: begin
                    if (w_acc) begin
                        r_main  <= w_in;
                        r_state <= S_ONE;
                    end
                end
                S_ONE: begin
                    if (w_fire && w_acc) begin
                        r_main <= w_in;
                    end else if (w_fire) begin
                        r_state <= S_EMPTY;
                    end else if (w_acc) begin
                        r_skid  <= w_in;
                        r_state <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (w_fire) begin
                        r_main  <= r_skid;
                        r_state <= S_ONE;
                    end
                end
                default: r_state <= S_EMPTY;
            endcase
        end
    end

endmodule
